fwd_hazard_ctrl: RTL and testbench
==================================

// Module: fwd_hazard_ctrl
// PURPOSE
//  Operand-forwarding and load-use hazard controller for the 5-stage pipeline.
//  Tracks destination info for the EX/MEM/WB stages and drives registered 2-bit selects for the two ALU-operand mux3to1 instances.
//  Select encoding: 0 = register file, 1 = EX/MEM result, 2 = MEM/WB result.
//  Also generates the ID stall and the EX bubble for load-use hazards.
// PARAMETERS
//  REG_AW   5   register-address width
//  CNT_W    32  width of statistics counters (FWD_STATS_EN only)
// PORTS
//  clk         in   1       pipeline clock; all state on rising edge
//  rst         in   1       asynchronous, active-high reset
//  id_valid    in   1       ID stage holds a real instruction
//  id_rs       in   REG_AW  ID source A
//  id_rt       in   REG_AW  ID source B
//  id_uses_rt  in   1       source B is a register operand (not immediate)
//  id_rd       in   REG_AW  ID destination
//  id_we       in   1       ID instruction writes id_rd
//  id_load     in   1       ID instruction is a load
//  flush       in   1       taken branch: squash ID->EX transfer
//  freeze      in   1       global pipeline freeze (memory busy)
//  stall_id    out  1       hold PC and IF/ID register (combinational)
//  bubble_ex   out  1       EX holds a bubble this cycle (registered)
//  fwd_a_sel   out  2       ALU operand A mux select (registered)
//  fwd_b_sel   out  2       ALU operand B mux select (registered)
// BEHAVIOUR
//  - Reset: all tracker we/load bits 0, rd fields 0, fwd_*_sel=0, bubble_ex=1, state=RUN.
//  - Trackers: ex_{rd,we,load} -> mem_{rd,we} -> wb_{rd,we}; shift every edge unless freeze.
//  - Hazard term haz = ex_load & ex_we & ex_rd!=0 & id_valid &
//    (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
//  - stall_id = haz & ~flush & ~freeze & (state==RUN); combinational, same cycle.
//  - Select computation per operand r in {id_rs, id_rt}, registered into EX:
//    - ex_we & ex_rd!=0 & ex_rd==r -> 1.
//    - else mem_we & mem_rd!=0 & mem_rd==r -> 2.
//    - else 0.
//    - Newest producer wins. Register 0 is never forwarded.
//    - fwd_b_sel is forced to 0 when ~id_uses_rt.
//  - EX load on a non-freeze edge:
//    - flush, stall_id or ~id_valid: ex_we=0, ex_load=0, sels=0, bubble_ex=1.
//    - otherwise: ex_* <= id_*, sels as computed, bubble_ex=0.
//  - FSM (2 states), freeze holds the state:
//    - RUN -> LU_STALL when stall_id.
//    - LU_STALL -> RUN unconditionally.
//    - In LU_STALL the load is in MEM, so the held instruction gets sel=2.
//    - Load-use latency is exactly 1 bubble.
//  - freeze has top priority: trackers, sels, bubble_ex and state hold; stall_id=0.
//  - flush beats hazard: no stall, bubble inserted, state stays/returns RUN.
//  - WB to ID needs no forwarding: the register file writes in the first half-cycle.
//  - Async reset mid-stall: returns to RUN with an empty pipeline image on assertion.
// CONFIGURATION
//  - FWD_STATS_EN defined: adds outputs fwd_cnt[CNT_W] and stall_cnt[CNT_W].
//    - fwd_cnt increments once per non-freeze EX load with any sel!=0.
//    - stall_cnt increments per cycle stall_id=1.
//    - Both reset to 0 and wrap modulo 2^CNT_W.
//  - FWD_STATS_EN undefined: no counters and no ports; behaviour otherwise identical.
// STRUCTURE
//  - Package cpu_pipe_pkg: FWD_RF=2'd0, FWD_MEM=2'd1, FWD_WB=2'd2; state enum RUN/LU_STALL.
//  - Sub-module fwd_sel_cmp: combinational comparator, one instance per operand.
//    - Inputs: r, ex_rd/we, mem_rd/we. Output: 2-bit sel.
// TESTING
//  1. ADD r3 then SUB rs=r3 back-to-back -> next cycle fwd_a_sel=1, bubble_ex=0, no stall.
//  2. ADD r3, NOP, OR rt=r3 (id_uses_rt=1) -> fwd_b_sel=2 when OR enters EX.
//  3. LW r5 then ADD rs=r5 -> stall_id=1 for 1 cycle, bubble_ex=1, then fwd_a_sel=2.
//  4. Producer rd=0, consumer rs=0 -> sel=0. Both EX and MEM write r7, consumer reads r7 -> sel=1.
//  5. flush with load-use hazard present -> stall_id=0, bubble_ex=1, sels=0.
//     freeze for 3 cycles -> all outputs hold.
//  6. rst asserted during LU_STALL -> outputs at reset values immediately.
//     (FWD_STATS_EN) fwd_cnt and stall_cnt match scenario counts 1/1/1/1/0.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Purpose: shared forwarding-select codes and load-use FSM state type for the pipeline control blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pipe_pkg;

    // ALU operand mux3to1 select codes
    localparam logic [1:0] FWD_RF  = 2'd0;   // register file read value
    localparam logic [1:0] FWD_MEM = 2'd1;   // EX/MEM pipeline register result
    localparam logic [1:0] FWD_WB  = 2'd2;   // MEM/WB pipeline register result

    // Load-use controller state
    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } lu_state_t;

endpackage

// File: rtl/fwd_sel_cmp.sv
// Purpose: picks the forwarding source for one ALU operand; the newest producer wins and r0 is never forwarded.
// Latency: combinational.
// Backpressure: none; the caller decides when the select is captured.
module fwd_sel_cmp
    import cpu_pipe_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_r,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic              i_ex_we,
    input  logic [REG_AW-1:0] i_mem_rd,
    input  logic              i_mem_we,
    output logic [1:0]        o_sel
);

    logic w_ex_hit;
    logic w_mem_hit;

    assign w_ex_hit  = i_ex_we  & (i_ex_rd  != '0) & (i_ex_rd  == i_r);
    assign w_mem_hit = i_mem_we & (i_mem_rd != '0) & (i_mem_rd == i_r);

    // EX producer is younger than MEM producer, so it takes priority
    always_comb begin
        o_sel = FWD_RF;
        if (w_ex_hit) begin
            o_sel = FWD_MEM;
        end else if (w_mem_hit) begin
            o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Purpose: operand-forwarding selects and load-use stall/bubble control for the 5-stage pipeline.
// Latency: selects/bubble registered into EX (1 cycle); stall_id combinational; load-use costs exactly 1 bubble.
// Backpressure: freeze holds all state and masks stall_id; flush squashes ID->EX. FWD_STATS_EN adds fwd_cnt/stall_cnt.
module fwd_hazard_ctrl
    import cpu_pipe_pkg::*;
#(
    parameter int REG_AW = 5
`ifdef FWD_STATS_EN
    ,
    parameter int CNT_W  = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_we,
    input  logic              id_load,
    input  logic              flush,
    input  logic              freeze,
    output logic              stall_id,
    output logic              bubble_ex,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel
`ifdef FWD_STATS_EN
    ,
    output logic [CNT_W-1:0]  fwd_cnt,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    // Destination image of the instructions in EX and MEM. The WB image is not
    // kept: the register file writes in the first half-cycle, so a WB producer
    // is already visible to ID and never needs a forwarding path.
    logic [REG_AW-1:0] r_ex_rd;
    logic              r_ex_we;
    logic              r_ex_load;
    logic [REG_AW-1:0] r_mem_rd;
    logic              r_mem_we;

    logic              r_bubble_ex;
    logic [1:0]        r_fwd_a_sel;
    logic [1:0]        r_fwd_b_sel;

    lu_state_t         r_state;
    lu_state_t         w_state_nxt;

    logic              w_haz;
    logic              w_stall;
    logic              w_issue;
    logic [1:0]        w_sel_a;
    logic [1:0]        w_sel_b_raw;
    logic [1:0]        w_sel_b;

    fwd_sel_cmp #(.REG_AW(REG_AW)) u_cmp_a (
        .i_r      (id_rs),
        .i_ex_rd  (r_ex_rd),
        .i_ex_we  (r_ex_we),
        .i_mem_rd (r_mem_rd),
        .i_mem_we (r_mem_we),
        .o_sel    (w_sel_a)
    );

    fwd_sel_cmp #(.REG_AW(REG_AW)) u_cmp_b (
        .i_r      (id_rt),
        .i_ex_rd  (r_ex_rd),
        .i_ex_we  (r_ex_we),
        .i_mem_rd (r_mem_rd),
        .i_mem_we (r_mem_we),
        .o_sel    (w_sel_b_raw)
    );

    // An immediate operand B must never pick up a forwarded value
    assign w_sel_b = id_uses_rt ? w_sel_b_raw : FWD_RF;

    // A load in EX cannot supply its data until it reaches MEM
    assign w_haz = r_ex_load & r_ex_we & (r_ex_rd != '0) & id_valid &
                   ((r_ex_rd == id_rs) | (id_uses_rt & (r_ex_rd == id_rt)));

    assign w_stall  = w_haz & ~flush & ~freeze & (r_state == RUN);
    assign stall_id = w_stall;

    // A real instruction moves into EX only when it is not squashed or held
    assign w_issue = id_valid & ~flush & ~w_stall;

    assign bubble_ex = r_bubble_ex;
    assign fwd_a_sel = r_fwd_a_sel;
    assign fwd_b_sel = r_fwd_b_sel;

    // Load-use FSM next state: one stall cycle, then the load sits in MEM
    always_comb begin
        w_state_nxt = r_state;
        if (!freeze) begin
            case (r_state)
                RUN:      w_state_nxt = w_stall ? LU_STALL : RUN;
                LU_STALL: w_state_nxt = RUN;
                default:  w_state_nxt = RUN;
            endcase
        end
    end

    // Load-use FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pipeline image shift and EX-stage select/bubble capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_rd     <= '0;
            r_ex_we     <= 1'b0;
            r_ex_load   <= 1'b0;
            r_mem_rd    <= '0;
            r_mem_we    <= 1'b0;
            r_bubble_ex <= 1'b1;
            r_fwd_a_sel <= FWD_RF;
            r_fwd_b_sel <= FWD_RF;
        end else if (!freeze) begin
            r_mem_rd <= r_ex_rd;
            r_mem_we <= r_ex_we;
            r_ex_rd  <= id_rd;
            if (w_issue) begin
                r_ex_we     <= id_we;
                r_ex_load   <= id_load;
                r_fwd_a_sel <= w_sel_a;
                r_fwd_b_sel <= w_sel_b;
                r_bubble_ex <= 1'b0;
            end else begin
                r_ex_we     <= 1'b0;
                r_ex_load   <= 1'b0;
                r_fwd_a_sel <= FWD_RF;
                r_fwd_b_sel <= FWD_RF;
                r_bubble_ex <= 1'b1;
            end
        end
    end

`ifdef FWD_STATS_EN
    logic [CNT_W-1:0] r_fwd_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    assign fwd_cnt   = r_fwd_cnt;
    assign stall_cnt = r_stall_cnt;

    // Statistics: forwarded EX loads and load-use stall cycles, wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fwd_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (!freeze && w_issue && ((w_sel_a != FWD_RF) || (w_sel_b != FWD_RF))) begin
                r_fwd_cnt <= r_fwd_cnt + CNT_W'(1);
            end
            if (w_stall) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Purpose: self-checking bench for fwd_hazard_ctrl; instruction-level model plus directed pinned checks and random traffic.
// Latency: model predicts registered outputs one edge after issue, stall_id in the same cycle.
// Backpressure: exercises freeze and flush; covers FWD_STATS_EN counters when the macro is defined.
module tb_fwd_hazard_ctrl;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_uses_rt;
    logic [AW-1:0] id_rd;
    logic          id_we;
    logic          id_load;
    logic          flush;
    logic          freeze;
    logic          stall_id;
    logic          bubble_ex;
    logic [1:0]    fwd_a_sel;
    logic [1:0]    fwd_b_sel;
`ifdef FWD_STATS_EN
    logic [31:0]   fwd_cnt;
    logic [31:0]   stall_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    fwd_hazard_ctrl #(.REG_AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .id_rd      (id_rd),
        .id_we      (id_we),
        .id_load    (id_load),
        .flush      (flush),
        .freeze     (freeze),
        .stall_id   (stall_id),
        .bubble_ex  (bubble_ex),
        .fwd_a_sel  (fwd_a_sel),
        .fwd_b_sel  (fwd_b_sel)
`ifdef FWD_STATS_EN
        ,
        .fwd_cnt    (fwd_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model: which instruction sits where ----------------
    typedef struct {
        bit          writes;
        bit          is_load;
        bit [AW-1:0] dst;
    } instr_t;

    instr_t      m_ex;
    instr_t      m_mem;
    bit [1:0]    m_sa;
    bit [1:0]    m_sb;
    bit          m_bub;
    int unsigned m_fcnt;
    int unsigned m_scnt;

    // Which stage holds the newest writer of register r (r0 never forwarded)
    function automatic bit [1:0] src_of(input bit [AW-1:0] r);
        if (r == 0) return 2'd0;
        if (m_ex.writes && m_ex.dst == r) return 2'd1;
        if (m_mem.writes && m_mem.dst == r) return 2'd2;
        return 2'd0;
    endfunction

    // ID must wait when it reads a register still being loaded by EX
    function automatic bit want_stall();
        bit reads;
        reads = (m_ex.dst == id_rs) || (id_uses_rt && m_ex.dst == id_rt);
        return id_valid && m_ex.is_load && m_ex.writes && m_ex.dst != 0 &&
               reads && !flush && !freeze;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ex   <= '{0, 0, 0};
            m_mem  <= '{0, 0, 0};
            m_sa   <= 0;
            m_sb   <= 0;
            m_bub  <= 1;
            m_fcnt <= 0;
            m_scnt <= 0;
        end else if (!freeze) begin
            bit       go;
            bit [1:0] a;
            bit [1:0] b;
            go = id_valid && !flush && !want_stall();
            a  = src_of(id_rs);
            b  = id_uses_rt ? src_of(id_rt) : 2'd0;
            m_mem <= m_ex;
            if (go) begin
                m_ex  <= '{id_we, id_load, id_rd};
                m_sa  <= a;
                m_sb  <= b;
                m_bub <= 0;
                if (a != 0 || b != 0) m_fcnt <= m_fcnt + 1;
            end else begin
                m_ex  <= '{0, 0, id_rd};
                m_sa  <= 0;
                m_sb  <= 0;
                m_bub <= 1;
            end
            if (want_stall()) m_scnt <= m_scnt + 1;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the clock edge
    always @(negedge clk) begin
        check("stall_id",  32'(stall_id),  32'(want_stall()));
        check("bubble_ex", 32'(bubble_ex), 32'(m_bub));
        check("fwd_a_sel", 32'(fwd_a_sel), 32'(m_sa));
        check("fwd_b_sel", 32'(fwd_b_sel), 32'(m_sb));
`ifdef FWD_STATS_EN
        check("fwd_cnt",   fwd_cnt,   m_fcnt);
        check("stall_cnt", stall_cnt, m_scnt);
`endif
    end

    // ---------------- stimulus helpers ----------------
    task automatic setin(input bit v, input int rs, input int rt, input bit urt,
                         input int rd, input bit we, input bit ld,
                         input bit fl, input bit fz);
        id_valid   = v;
        id_rs      = AW'(rs);
        id_rt      = AW'(rt);
        id_uses_rt = urt;
        id_rd      = AW'(rd);
        id_we      = we;
        id_load    = ld;
        flush      = fl;
        freeze     = fz;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        #1;
        check("rst_bubble", 32'(bubble_ex), 32'd1);
        check("rst_sel_a",  32'(fwd_a_sel), 32'd0);
        check("rst_sel_b",  32'(fwd_b_sel), 32'd0);
        check("rst_stall",  32'(stall_id),  32'd0);
        rst = 1'b0;
        step();

        // 1: ADD r3 ; SUB rs=r3 -> EX/MEM forward on A
        setin(1, 1, 2, 1, 3, 1, 0, 0, 0); step();
        setin(1, 3, 2, 1, 4, 1, 0, 0, 0); #1;
        check("s1_stall", 32'(stall_id), 32'd0);
        step(); #1;
        check("s1_sel_a",  32'(fwd_a_sel), 32'd1);
        check("s1_sel_b",  32'(fwd_b_sel), 32'd0);
        check("s1_bubble", 32'(bubble_ex), 32'd0);

        // 2: ADD r3 ; NOP ; OR rt=r3 -> MEM/WB forward on B
        setin(1, 1, 2, 1, 3, 1, 0, 0, 0); step();
        setin(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        setin(1, 1, 3, 1, 6, 1, 0, 0, 0); step(); #1;
        check("s2_sel_b", 32'(fwd_b_sel), 32'd2);
        check("s2_sel_a", 32'(fwd_a_sel), 32'd0);

        // 3: LW r5 ; ADD rs=r5 -> one stall, one bubble, then MEM/WB forward
        setin(1, 1, 0, 0, 5, 1, 1, 0, 0); step();
        setin(1, 5, 0, 0, 8, 1, 0, 0, 0); #1;
        check("s3_stall", 32'(stall_id), 32'd1);
        step(); #1;
        check("s3_bubble", 32'(bubble_ex), 32'd1);
        check("s3_stall2", 32'(stall_id),  32'd0);
        step(); #1;
        check("s3_sel_a",   32'(fwd_a_sel), 32'd2);
        check("s3_bubble2", 32'(bubble_ex), 32'd0);

        // 4: r0 never forwarded; newest producer of r7 wins
        setin(1, 1, 0, 0, 0, 1, 0, 0, 0); step();
        setin(1, 0, 0, 1, 9, 1, 0, 0, 0); step(); #1;
        check("s4_r0_a", 32'(fwd_a_sel), 32'd0);
        check("s4_r0_b", 32'(fwd_b_sel), 32'd0);
        setin(1, 1, 0, 0, 7, 1, 0, 0, 0); step();
        setin(1, 2, 0, 0, 7, 1, 0, 0, 0); step();
        setin(1, 7, 0, 0, 10, 1, 0, 0, 0); step(); #1;
        check("s4_newest", 32'(fwd_a_sel), 32'd1);

        // 5: flush beats hazard; freeze holds everything and masks stall
        setin(1, 1, 0, 0, 5, 1, 1, 0, 0); step();
        setin(1, 5, 0, 0, 11, 1, 0, 1, 0); #1;
        check("s5_fl_stall", 32'(stall_id), 32'd0);
        step(); #1;
        check("s5_fl_bubble", 32'(bubble_ex), 32'd1);
        check("s5_fl_sel_a",  32'(fwd_a_sel), 32'd0);
        setin(1, 1, 0, 0, 5, 1, 1, 0, 0); step();
        setin(1, 5, 0, 0, 11, 1, 0, 0, 1); #1;
        check("s5_fz_stall", 32'(stall_id), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            check("s5_fz_bubble", 32'(bubble_ex), 32'd0);
            check("s5_fz_stallh", 32'(stall_id),  32'd0);
        end
        freeze = 1'b0; #1;
        check("s5_unfz_stall", 32'(stall_id), 32'd1);
        step();

        // 6: reset while in the load-use stall state
        rst = 1'b1; #1;
        check("s6_bubble", 32'(bubble_ex), 32'd1);
        check("s6_sel_a",  32'(fwd_a_sel), 32'd0);
        check("s6_stall",  32'(stall_id),  32'd0);
        step();
        rst = 1'b0;

        // Random traffic on a small register window so hazards are frequent
        for (int c = 0; c < 3000; c++) begin
            setin($urandom_range(0, 7) != 0,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1) != 0,
                  $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 299) == 0) rst = 1'b1;
            step();
            rst = 1'b0;
        end

        setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
